// File: rtl/ntoone_mux_pkg.sv
// Shared constants and helpers for the N-to-1 registered mux and its arbiter.
package ntoone_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ntoone_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping; owns ptr.
module ntoone_rr_arbiter
  import ntoone_mux_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  logic [SEL_W-1:0] ptr;
  int               idx;

  // Scan offsets from the far end back toward ptr so the closest requester wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant       = SEL_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant) == N - 1) ? '0 : grant + SEL_W'(1);
    end
  end

endmodule

// File: rtl/ntoone_mux_rr_reg.sv
// N-to-1 W-bit mux with registered valid/ready output; MODE selects external S or round-robin.
// Optional out_parity port enabled by defining NTOONE_MUX_PARITY_EN.
module ntoone_mux_rr_reg
  import ntoone_mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  parameter  int MODE  = MODE_SEL,
  localparam int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] S,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_chan,
  output logic             out_valid,
  input  logic             out_ready
`ifdef NTOONE_MUX_PARITY_EN
  ,output logic            out_parity
`endif
);

  logic             load;
  logic             xfer;
  logic             grant_valid;
  logic [SEL_W-1:0] grant;
  logic [W-1:0]     sel_data;

  assign load = !out_valid || out_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic unused_s;
      assign unused_s = ^S;

      ntoone_rr_arbiter #(.N(N)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (in_valid),
        .advance     (xfer),
        .grant       (grant),
        .grant_valid (grant_valid)
      );
    end else begin : g_sel
      // Matching against each legal index means an out-of-range S never grants.
      always_comb begin
        grant       = S;
        grant_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (S == SEL_W'(i) && in_valid[i]) grant_valid = 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    in_ready = '0;
    if (!rst && load && grant_valid) in_ready[grant] = 1'b1;
  end

  assign xfer     = |(in_valid & in_ready);
  assign sel_data = in_data[int'(grant)*W +: W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_chan  <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef NTOONE_MUX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (load && xfer) begin
      out_parity <= ^sel_data;
    end
  end
`endif

endmodule
